// File: rtl/lock_pkg.sv
// Shared key and state encodings for the keypad code-entry controller.
package lock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_e;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/code_entry_if.sv
// Keypad/programming inputs and status outputs of code_entry, grouped as one bus.
interface code_entry_if #(
  parameter int CODE_LEN = 4
) ();

  logic                    key_valid;
  logic [3:0]              key_code;
  logic                    prog_en;
  logic [4*CODE_LEN-1:0]   prog_code;
  logic                    entry_active;
  logic [2:0]              digit_count;
  logic                    entry_done;
  logic                    code_match;
  logic                    timeout_pulse;
  logic                    lockout;
  logic [1:0]              fail_count;

  modport master (
    output key_valid, key_code, prog_en, prog_code,
    input  entry_active, digit_count, entry_done, code_match,
           timeout_pulse, lockout, fail_count
  );

  modport slave (
    input  key_valid, key_code, prog_en, prog_code,
    output entry_active, digit_count, entry_done, code_match,
           timeout_pulse, lockout, fail_count
  );

endinterface

// File: rtl/cycle_timer.sv
// Loadable down-counter; o_expire flags the tick that consumes the last count.
module cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_tick,
  output logic             o_expire
);

  logic [WIDTH-1:0] r_cnt;

  assign o_expire = i_tick && (r_cnt == WIDTH'(1));

  // Count register: load has priority, then decrement on tick, stopping at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/code_entry.sv
// Keypad code-entry controller: buffers digits, checks them against a programmable
// stored code, abandons idle entries and locks out after repeated failures.
module code_entry
  import lock_pkg::*;
#(
  parameter int                    CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] RESET_CODE     = 16'h1234,
  parameter int                    TIMEOUT        = 1000,
  parameter int                    MAX_ATTEMPTS   = 3,
  parameter int                    LOCKOUT_CYCLES = 5000
) (
  input logic        clk,
  input logic        reset,
  code_entry_if.slave bus
);

  localparam int              BUF_W     = 4*CODE_LEN;
  localparam int              TO_W      = $clog2(TIMEOUT + 1);
  localparam int              LO_W      = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [2:0]      FULL_CNT  = 3'(CODE_LEN);
  localparam logic [1:0]      FAIL_MAX  = 2'(MAX_ATTEMPTS);
  localparam logic [1:0]      FAIL_LAST = 2'(MAX_ATTEMPTS - 1);
  localparam logic [TO_W-1:0] TO_LOAD   = TO_W'(TIMEOUT);
  localparam logic [LO_W-1:0] LO_LOAD   = LO_W'(LOCKOUT_CYCLES);

  state_e             r_state, w_state_nxt;
  logic [BUF_W-1:0]   r_buf, w_buf_nxt;
  logic [BUF_W-1:0]   r_stored, w_stored_nxt;
  logic [2:0]         r_cnt, w_cnt_nxt;
  logic [1:0]         r_fail, w_fail_nxt;
  logic               r_done, w_done_nxt;
  logic               r_match, w_match_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic               r_active, r_lockout;
  logic               w_is_digit, w_is_clear, w_is_enter, w_key_acc, w_match_now;
  logic               w_to_load, w_to_tick, w_to_exp;
  logic               w_lo_load, w_lo_tick, w_lo_exp;

  assign w_is_digit  = bus.key_valid && is_digit(bus.key_code);
  assign w_is_clear  = bus.key_valid && (bus.key_code == KEY_CLEAR);
  assign w_is_enter  = bus.key_valid && (bus.key_code == KEY_ENTER);
  assign w_key_acc   = w_is_digit || w_is_clear || w_is_enter;
  assign w_match_now = (r_cnt == FULL_CNT) && (r_buf == r_stored);
  // A key in the expiry cycle suppresses the tick, so the key always wins.
  assign w_to_tick   = (r_state == ST_COLLECT) && !w_key_acc;
  assign w_lo_tick   = (r_state == ST_LOCKOUT);

  cycle_timer #(.WIDTH(TO_W)) u_idle_timer (
    .clk       (clk),
    .rst       (reset),
    .i_load    (w_to_load),
    .i_load_val(TO_LOAD),
    .i_tick    (w_to_tick),
    .o_expire  (w_to_exp)
  );

  cycle_timer #(.WIDTH(LO_W)) u_lockout_timer (
    .clk       (clk),
    .rst       (reset),
    .i_load    (w_lo_load),
    .i_load_val(LO_LOAD),
    .i_tick    (w_lo_tick),
    .o_expire  (w_lo_exp)
  );

  // Next-state, datapath and output-pulse decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_buf_nxt     = r_buf;
    w_cnt_nxt     = r_cnt;
    w_stored_nxt  = r_stored;
    w_fail_nxt    = r_fail;
    w_done_nxt    = 1'b0;
    w_match_nxt   = 1'b0;
    w_timeout_nxt = 1'b0;
    w_to_load     = 1'b0;
    w_lo_load     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_is_digit) begin
          w_buf_nxt   = BUF_W'(bus.key_code);
          w_cnt_nxt   = 3'd1;
          w_state_nxt = ST_COLLECT;
          w_to_load   = 1'b1;
        end else if (!bus.key_valid && bus.prog_en) begin
          w_stored_nxt = bus.prog_code;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (w_key_acc) begin
          w_to_load = 1'b1;
          if (w_is_digit) begin
            if (r_cnt < FULL_CNT) begin
              w_buf_nxt = {r_buf[BUF_W-5:0], bus.key_code};
              w_cnt_nxt = r_cnt + 3'd1;
            end else begin
              w_cnt_nxt = r_cnt;
            end
          end else if (w_is_clear) begin
            w_buf_nxt   = '0;
            w_cnt_nxt   = 3'd0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_done_nxt  = 1'b1;
            w_match_nxt = w_match_now;
            w_buf_nxt   = '0;
            w_cnt_nxt   = 3'd0;
            if (w_match_now) begin
              w_fail_nxt  = 2'd0;
              w_state_nxt = ST_IDLE;
            end else if (r_fail == FAIL_LAST) begin
              w_fail_nxt  = FAIL_MAX;
              w_state_nxt = ST_LOCKOUT;
              w_lo_load   = 1'b1;
            end else begin
              w_fail_nxt  = r_fail + 2'd1;
              w_state_nxt = ST_IDLE;
            end
          end
        end else if (w_to_exp) begin
          w_timeout_nxt = 1'b1;
          w_buf_nxt     = '0;
          w_cnt_nxt     = 3'd0;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_state_nxt = ST_COLLECT;
        end
      end
      ST_LOCKOUT: begin
        if (w_lo_exp) begin
          w_fail_nxt  = 2'd0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_LOCKOUT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_buf_nxt   = '0;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_buf     <= '0;
      r_cnt     <= 3'd0;
      r_stored  <= RESET_CODE;
      r_fail    <= 2'd0;
      r_done    <= 1'b0;
      r_match   <= 1'b0;
      r_timeout <= 1'b0;
      r_active  <= 1'b0;
      r_lockout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_buf     <= w_buf_nxt;
      r_cnt     <= w_cnt_nxt;
      r_stored  <= w_stored_nxt;
      r_fail    <= w_fail_nxt;
      r_done    <= w_done_nxt;
      r_match   <= w_match_nxt;
      r_timeout <= w_timeout_nxt;
      r_active  <= (w_state_nxt == ST_COLLECT);
      r_lockout <= (w_state_nxt == ST_LOCKOUT);
    end
  end

  assign bus.entry_active  = r_active;
  assign bus.digit_count   = r_cnt;
  assign bus.entry_done    = r_done;
  assign bus.code_match    = r_match;
  assign bus.timeout_pulse = r_timeout;
  assign bus.lockout       = r_lockout;
  assign bus.fail_count    = r_fail;

endmodule

// File: tb/tb_code_entry.sv
// Scoreboard bench for code_entry: a keypad model queues expected entry/timeout
// events as keys are driven, and a negedge monitor pops and compares them.
module tb_code_entry;
  import lock_pkg::*;

  localparam int CODE_LEN       = 4;
  localparam int TIMEOUT        = 16;
  localparam int LOCKOUT_CYCLES = 32;

  typedef struct packed {
    logic       is_to;
    logic       match;
    logic [1:0] fail;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  code_entry_if #(.CODE_LEN(CODE_LEN)) bus ();

  code_entry #(
    .CODE_LEN      (CODE_LEN),
    .RESET_CODE    (16'h1234),
    .TIMEOUT       (TIMEOUT),
    .MAX_ATTEMPTS  (3),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t        sb_q[$];
  exp_t        sb_e;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] m_buf, m_stored;
  int          m_cnt, m_fail;
  bit          m_active, m_lock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_buf    = 16'h0000;
    m_stored = 16'h1234;
    m_cnt    = 0;
    m_fail   = 0;
    m_active = 1'b0;
    m_lock   = 1'b0;
    sb_q.delete();
  endtask

  task automatic model_clear();
    m_buf    = 16'h0000;
    m_cnt    = 0;
    m_active = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Update the model, drive one key for one cycle, then check the visible state.
  task automatic press(input logic [3:0] k);
    exp_t e;
    bit   pushed;
    pushed = 1'b0;
    if (!m_lock) begin
      if (k <= 4'd9) begin
        if (!m_active) begin
          m_buf    = {12'h000, k};
          m_cnt    = 1;
          m_active = 1'b1;
        end else if (m_cnt < CODE_LEN) begin
          m_buf = {m_buf[11:0], k};
          m_cnt++;
        end
      end else if (k == KEY_CLEAR && m_active) begin
        model_clear();
      end else if (k == KEY_ENTER && m_active) begin
        e.is_to = 1'b0;
        e.match = (m_cnt == CODE_LEN) && (m_buf == m_stored);
        m_fail  = e.match ? 0 : m_fail + 1;
        e.fail  = 2'(m_fail);
        sb_q.push_back(e);
        pushed  = 1'b1;
        if (m_fail == 3) m_lock = 1'b1;
        model_clear();
      end
    end
    bus.key_valid = 1'b1;
    bus.key_code  = k;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    check_eq("digit_count", 32'(bus.digit_count), 32'(m_cnt));
    check_eq("entry_active", 32'(bus.entry_active), 32'(m_active));
    check_eq("lockout", 32'(bus.lockout), 32'(m_lock));
    if (pushed) check_eq("done_latency", 32'(bus.entry_done), 32'd1);
  endtask

  task automatic enter_code(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) press(code[4*i +: 4]);
    press(KEY_ENTER);
  endtask

  // Monitor: pop an expectation for every entry_done / timeout_pulse seen.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.entry_done || bus.timeout_pulse) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected", {30'd0, bus.entry_done, bus.timeout_pulse}, 32'd0);
        end else begin
          sb_e = sb_q.pop_front();
          check_eq("sb_kind", 32'(bus.timeout_pulse), 32'(sb_e.is_to));
          if (!sb_e.is_to) begin
            check_eq("sb_match", 32'(bus.code_match), 32'(sb_e.match));
            check_eq("sb_fail", 32'(bus.fail_count), 32'(sb_e.fail));
          end
        end
      end
      if (!bus.entry_done) check_eq("match_qualified", 32'(bus.code_match), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset         = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.prog_en   = 1'b0;
    bus.prog_code = 16'h0000;
    model_reset();
    idle(2);
    check_eq("rst_active", 32'(bus.entry_active), 32'd0);
    check_eq("rst_count", 32'(bus.digit_count), 32'd0);
    check_eq("rst_done", 32'(bus.entry_done), 32'd0);
    check_eq("rst_match", 32'(bus.code_match), 32'd0);
    check_eq("rst_timeout", 32'(bus.timeout_pulse), 32'd0);
    check_eq("rst_lockout", 32'(bus.lockout), 32'd0);
    check_eq("rst_fail", 32'(bus.fail_count), 32'd0);
    reset = 1'b0;
    idle(1);

    // Correct code, short code, CLEAR mid-entry, dropped fifth digit.
    enter_code(16'h1234);
    press(4'd1); press(4'd2); press(4'd3); press(KEY_ENTER);
    press(4'd1); press(4'd2); press(KEY_CLEAR);
    enter_code(16'h1234);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5); press(KEY_ENTER);
    idle(2);

    // Idle timeout after TIMEOUT quiet cycles.
    press(4'd5);
    idle(TIMEOUT - 1);
    check_eq("to_pre_active", 32'(bus.entry_active), 32'd1);
    sb_q.push_back('{is_to: 1'b1, match: 1'b0, fail: 2'(m_fail)});
    model_clear();
    idle(1);
    check_eq("to_pulse", 32'(bus.timeout_pulse), 32'd1);
    check_eq("to_count", 32'(bus.digit_count), 32'd0);
    check_eq("to_active", 32'(bus.entry_active), 32'd0);
    idle(2);

    // A key in the expiry cycle wins over the timeout.
    press(4'd5);
    idle(TIMEOUT - 1);
    press(4'd5);
    check_eq("key_wins", 32'(bus.timeout_pulse), 32'd0);
    press(KEY_CLEAR);
    idle(2);

    // Three wrong codes lock out; keys ignored for the lockout period.
    enter_code(16'h1111);
    enter_code(16'h2222);
    enter_code(16'h3333);
    enter_code(16'h1234);
    idle(LOCKOUT_CYCLES - 6);
    check_eq("lo_last_cycle", 32'(bus.lockout), 32'd1);
    check_eq("lo_fail_held", 32'(bus.fail_count), 32'd3);
    idle(1);
    m_lock = 1'b0;
    m_fail = 0;
    check_eq("lo_released", 32'(bus.lockout), 32'd0);
    check_eq("lo_fail_zero", 32'(bus.fail_count), 32'd0);
    enter_code(16'h1234);

    // Program a new code in IDLE; programming during entry is ignored.
    bus.prog_en   = 1'b1;
    bus.prog_code = 16'h9876;
    m_stored      = 16'h9876;
    idle(1);
    bus.prog_en   = 1'b0;
    enter_code(16'h9876);
    enter_code(16'h1234);
    press(4'd9);
    bus.prog_en   = 1'b1;
    bus.prog_code = 16'h1111;
    idle(1);
    bus.prog_en   = 1'b0;
    press(4'd8); press(4'd7); press(4'd6); press(KEY_ENTER);
    idle(2);

    // Asynchronous reset mid-entry discards progress and restores the reset code.
    enter_code(16'h5555);
    press(4'd1); press(4'd2);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_count", 32'(bus.digit_count), 32'd0);
    check_eq("arst_active", 32'(bus.entry_active), 32'd0);
    check_eq("arst_fail", 32'(bus.fail_count), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);
    enter_code(16'h1234);
    idle(3);
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/code_entry.md
CODE_ENTRY -- requirements
Module: code_entry

Interface
REQ-001 SHALL have parameter CODE_LEN, default 4: number of digits in a code.
REQ-002 SHALL have parameter RESET_CODE, default 16'h1234: stored code after reset, 4 bits per digit, first digit in the MSBs.
REQ-003 SHALL have parameter TIMEOUT, default 1000: idle cycles in COLLECT before entry is abandoned.
REQ-004 SHALL have parameter MAX_ATTEMPTS, default 3: consecutive failed entries that trigger lockout.
REQ-005 SHALL have parameter LOCKOUT_CYCLES, default 5000: lockout duration in cycles.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port key_valid, input, 1 bit: one-cycle key strobe.
REQ-009 SHALL have port key_code, input, 4 bits: 0-9 are digits, 4'hA is CLEAR, 4'hB is ENTER, 4'hC-4'hF are ignored.
REQ-010 SHALL have port prog_en, input, 1 bit: request to load a new stored code.
REQ-011 SHALL have port prog_code, input, 4*CODE_LEN bits: the new stored code.
REQ-012 SHALL have port entry_active, output, 1 bit: high while in COLLECT.
REQ-013 SHALL have port digit_count, output, 3 bits: number of digits buffered.
REQ-014 SHALL have port entry_done, output, 1 bit: one-cycle pulse marking a completed entry.
REQ-015 SHALL have port code_match, output, 1 bit: match result, qualified by entry_done.
REQ-016 SHALL have port timeout_pulse, output, 1 bit: one-cycle pulse on entry timeout.
REQ-017 SHALL have port lockout, output, 1 bit: high during lockout.
REQ-018 SHALL have port fail_count, output, 2 bits: consecutive failed entries.

Function
REQ-019 SHALL implement states IDLE, COLLECT and LOCKOUT.
REQ-020 In IDLE, a digit key SHALL be stored as the first digit, set digit_count to 1 and move to COLLECT; CLEAR and ENTER SHALL be ignored.
REQ-021 In COLLECT, a digit key with digit_count < CODE_LEN SHALL shift into the buffer and increment digit_count; with digit_count == CODE_LEN it SHALL be dropped.
REQ-022 In COLLECT, CLEAR SHALL zero the buffer and digit_count and return to IDLE, with no entry_done.
REQ-023 In COLLECT, ENTER SHALL register entry_done=1 and code_match=(digit_count==CODE_LEN && buffer==stored) for exactly the next cycle, then clear the buffer and count and return to IDLE.
REQ-024 code_match SHALL be 0 whenever entry_done is 0.
REQ-025 The idle counter SHALL restart on every accepted key in COLLECT; after TIMEOUT cycles with no key it SHALL pulse timeout_pulse for 1 cycle, clear the buffer and return to IDLE; timeouts SHALL NOT count as failures.
REQ-026 If a key and timeout expiry fall in the same cycle, the key SHALL win and no timeout SHALL occur.
REQ-027 A match SHALL zero fail_count; a mismatch SHALL increment it.
REQ-028 When a mismatch brings fail_count to MAX_ATTEMPTS, the block SHALL enter LOCKOUT on the cycle entry_done is high.
REQ-029 In LOCKOUT, lockout SHALL be 1 and all keys SHALL be ignored; after LOCKOUT_CYCLES it SHALL return to IDLE with fail_count=0 and lockout=0.
REQ-030 prog_en SHALL load prog_code into the stored code only in IDLE with key_valid=0; otherwise it SHALL be ignored.

Reset
REQ-031 reset SHALL immediately force state IDLE, with buffer, digit_count, both counters and fail_count at 0, stored code = RESET_CODE, and all outputs 0.
REQ-032 Reset mid-entry or mid-lockout SHALL discard all progress, with no entry_done or timeout_pulse.

Structure
REQ-033 Key encodings (KEY_CLEAR, KEY_ENTER) and state encodings SHALL live in the shared package lock_pkg.
REQ-034 The idle timeout and lockout SHALL each use an instance of the sub-module cycle_timer (load, tick, expire), parameterised by width.

Verification
REQ-035 SHALL cover: keys 1,2,3,4,ENTER -> entry_done=1 and code_match=1 the cycle after ENTER; fail_count=0.
REQ-036 SHALL cover: keys 1,2,3,ENTER -> entry_done=1, code_match=0, fail_count=1.
REQ-037 SHALL cover: keys 1,2,CLEAR,1,2,3,4,ENTER -> no pulse on CLEAR, then match=1; a fifth digit before ENTER is dropped and match=1.
REQ-038 SHALL cover, with TIMEOUT=16: key 5 then 16 idle cycles -> timeout_pulse=1, digit_count=0, entry_active=0; key 5 on cycle 16 -> no timeout.
REQ-039 SHALL cover, with LOCKOUT_CYCLES=32: three wrong codes -> lockout=1; keys are ignored for 32 cycles; then lockout=0 and fail_count=0.
REQ-040 SHALL cover: prog_en in IDLE with code 16'h9876 -> 9,8,7,6,ENTER matches; prog_en during COLLECT is ignored; reset asserted mid-entry clears everything asynchronously.
